load_sequencer: RTL and testbench

Upstream command stage for the 4-bit synchronous loadable counter. It accepts load values over a valid/ready request port and buffers them in a small FIFO. Each value is issued to the counter as a one-cycle ld_en pulse with load held, with a programmable number of idle cycles between pulses. The cycle after each pulse, it compares the counter's output against the issued value and flags mismatches in a sticky error bit.

---
 rtl/load_seq_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/load_sequencer.sv | 135 +++++++++++++
 tb/tb_load_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/load_seq_pkg.sv
// Shared definitions for the load sequencer slice.
//   seq_state_e : sequencer FSM states (2-bit encoding)
//   DEF_*       : default WIDTH / DEPTH / GAP parameter values
//   LEVEL_W()   : width of a FIFO occupancy count, log2(depth)+1
package load_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CHECK = 2'd2,
      WAIT  = 2'd3
   } seq_state_e;

   localparam int unsigned DEF_WIDTH = 4;
   localparam int unsigned DEF_DEPTH = 4;
   localparam int unsigned DEF_GAP   = 1;

   function automatic int unsigned LEVEL_W(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk     : clock, all state on posedge
//   Rst     : synchronous active-high reset, empties the FIFO
//   wr_en   : write request, ignored while full
//   wr_data : write data
//   rd_en   : read (pop) request, ignored while empty
//   rd_data : head entry, valid whenever empty is low
//   full    : no free entries
//   empty   : no stored entries
//   level   : current occupancy
module sync_fifo
   import load_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic                        clk,
   input  logic                        Rst,
   input  logic                        wr_en,
   input  logic [WIDTH-1:0]            wr_data,
   input  logic                        rd_en,
   output logic [WIDTH-1:0]            rd_data,
   output logic                        full,
   output logic                        empty,
   output logic [LEVEL_W(DEPTH)-1:0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = LEVEL_W(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   // Pointers carry one extra bit so equal addresses with differing MSBs
   // mean full rather than empty.
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             push;
   logic             pop;

   assign level   = wr_ptr_q - rd_ptr_q;
   assign full    = (level == LW'(DEPTH));
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/load_sequencer.sv
// Command stage feeding a loadable counter: buffers load values, issues
// each as a one-cycle ld_en pulse with at least GAP idle cycles between
// pulses, and checks the counter output the cycle after each pulse.
//   clk       : clock, all state on posedge
//   Rst       : synchronous active-high reset
//   req_valid : request carries a load value
//   req_data  : load value
//   req_ready : FIFO can accept (not full)
//   ld_en     : registered load strobe to the counter
//   load      : registered load value, held until the next issue
//   count_in  : counter output, compared in CHECK
//   err_clr   : clears load_err (a same-cycle mismatch takes priority)
//   load_err  : sticky registered mismatch flag
//   busy      : FIFO non-empty or FSM not idle
//   level     : FIFO occupancy
module load_sequencer
   import load_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned GAP   = DEF_GAP
) (
   input  logic                        clk,
   input  logic                        Rst,
   input  logic                        req_valid,
   input  logic [WIDTH-1:0]            req_data,
   output logic                        req_ready,
   output logic                        ld_en,
   output logic [WIDTH-1:0]            load,
   input  logic [WIDTH-1:0]            count_in,
   input  logic                        err_clr,
   output logic                        load_err,
   output logic                        busy,
   output logic [LEVEL_W(DEPTH)-1:0]   level
);

   localparam int unsigned GW = $clog2(GAP + 1);
   // WAIT spans GAP-1 cycles; CHECK supplies the first idle cycle.
   localparam logic [GW-1:0] GAP_INIT = (GAP > 1) ? GW'(GAP - 2) : '0;
   localparam logic [GW-1:0] GAP_ONE  = 1;

   seq_state_e       state_q;
   logic             ld_en_q;
   logic [WIDTH-1:0] load_q;
   logic             load_err_q;
   logic [GW-1:0]    gap_cnt_q;

   logic             fifo_full;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_rdata;
   logic             pop;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .Rst     (Rst),
      .wr_en   (req_valid),
      .wr_data (req_data),
      .rd_en   (pop),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   assign req_ready = !fifo_full;
   assign busy      = !fifo_empty || (state_q != IDLE);
   assign ld_en     = ld_en_q;
   assign load      = load_q;
   assign load_err  = load_err_q;

   always_comb begin
      pop = 1'b0;
      unique case (state_q)
         IDLE:    pop = !fifo_empty;
         CHECK:   pop = (GAP == 1) && !fifo_empty;
         WAIT:    pop = (gap_cnt_q == '0) && !fifo_empty;
         default: pop = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         state_q    <= IDLE;
         ld_en_q    <= 1'b0;
         load_q     <= '0;
         load_err_q <= 1'b0;
         gap_cnt_q  <= '0;
      end else begin
         ld_en_q <= 1'b0;
         if (pop) begin
            load_q  <= fifo_rdata;
            ld_en_q <= 1'b1;
         end

         if ((state_q == CHECK) && (count_in != load_q)) begin
            load_err_q <= 1'b1;
         end else if (err_clr) begin
            load_err_q <= 1'b0;
         end

         unique case (state_q)
            IDLE: begin
               if (pop) begin
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               state_q <= CHECK;
            end
            CHECK: begin
               if (pop) begin
                  state_q <= ISSUE;
               end else if (GAP > 1) begin
                  state_q   <= WAIT;
                  gap_cnt_q <= GAP_INIT;
               end else begin
                  state_q <= IDLE;
               end
            end
            WAIT: begin
               if (gap_cnt_q == '0) begin
                  state_q <= pop ? ISSUE : IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q - GAP_ONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_sequencer.sv
module tb_load_sequencer;

   logic       clk;
   logic       Rst;

   // GAP=1 instance
   logic       req_valid, req_ready, ld_en, err_clr, load_err, busy;
   logic [3:0] req_data, load, count_in;
   logic [2:0] level;
   logic       bad;

   // GAP=3 instance
   logic       req_valid3, req_ready3, ld_en3, err_clr3, load_err3, busy3;
   logic [3:0] req_data3, load3, count_in3;
   logic [2:0] level3;

   int n_chk  = 0;
   int n_fail = 0;

   logic [3:0] q[$];
   logic [3:0] q3[$];
   int         gaps3[$];
   int         lowrun3 = 0;
   logic       prev1 = 1'b0;
   logic       prev3 = 1'b0;

   load_sequencer #(.WIDTH(4), .DEPTH(4), .GAP(1)) dut (
      .clk(clk), .Rst(Rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .ld_en(ld_en), .load(load), .count_in(count_in),
      .err_clr(err_clr), .load_err(load_err), .busy(busy), .level(level)
   );

   load_sequencer #(.WIDTH(4), .DEPTH(4), .GAP(3)) dut3 (
      .clk(clk), .Rst(Rst), .req_valid(req_valid3), .req_data(req_data3),
      .req_ready(req_ready3), .ld_en(ld_en3), .load(load3), .count_in(count_in3),
      .err_clr(err_clr3), .load_err(load_err3), .busy(busy3), .level(level3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counter models; 'bad' makes the first one load 0000 instead.
   always @(posedge clk) begin
      if (Rst) count_in <= '0;
      else if (ld_en) count_in <= bad ? 4'b0000 : load;
   end

   always @(posedge clk) begin
      if (Rst) count_in3 <= '0;
      else if (ld_en3) count_in3 <= load3;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] v);
      req_data  = v;
      req_valid = 1'b1;
      if (req_ready) q.push_back(v);
      step();
      req_valid = 1'b0;
   endtask

   task automatic push3(input logic [3:0] v);
      req_data3  = v;
      req_valid3 = 1'b1;
      if (req_ready3) q3.push_back(v);
      step();
      req_valid3 = 1'b0;
   endtask

   // Scoreboard: every ld_en pulse must carry the next accepted value.
   always @(negedge clk) begin
      if (!Rst && ld_en) begin
         chk("nb2b_g1", 32'(prev1), 32'd0);
         if (q.size() == 0) chk("unexpected_pulse_g1", 32'(ld_en), 32'd0);
         else chk("sb_load_g1", 32'(load), 32'(q.pop_front()));
      end
      prev1 = ld_en;
   end

   always @(negedge clk) begin
      if (!Rst) begin
         if (ld_en3) begin
            chk("nb2b_g3", 32'(prev3), 32'd0);
            if (q3.size() == 0) chk("unexpected_pulse_g3", 32'(ld_en3), 32'd0);
            else chk("sb_load_g3", 32'(load3), 32'(q3.pop_front()));
            gaps3.push_back(lowrun3);
            lowrun3 = 0;
         end else begin
            lowrun3++;
         end
      end
      prev3 = ld_en3;
   end

   initial begin
      Rst = 1'b1; bad = 1'b0;
      req_valid = 1'b0; req_data = '0; err_clr = 1'b0;
      req_valid3 = 1'b0; req_data3 = '0; err_clr3 = 1'b0;
      step(); step();

      // reset state
      chk("rst_ld_en", 32'(ld_en), 32'd0);
      chk("rst_load", 32'(load), 32'd0);
      chk("rst_load_err", 32'(load_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_req_ready_g3", 32'(req_ready3), 32'd1);
      Rst = 1'b0;
      step();

      // single push latency
      push(4'b0011);
      chk("t1_level_N", 32'(level), 32'd1);
      chk("t1_ld_en_N", 32'(ld_en), 32'd0);
      step();
      chk("t1_ld_en_N1", 32'(ld_en), 32'd1);
      chk("t1_load_N1", 32'(load), 32'h3);
      step();
      chk("t1_ld_en_N2", 32'(ld_en), 32'd0);
      chk("t1_load_held", 32'(load), 32'h3);
      step();
      chk("t1_load_err", 32'(load_err), 32'd0);
      chk("t1_busy_done", 32'(busy), 32'd0);
      step();

      // back-to-back pushes, GAP=1
      push(4'b0011);
      chk("t2_level_a", 32'(level), 32'd1);
      push(4'b0110);
      chk("t2_ld_en_a", 32'(ld_en), 32'd1);
      chk("t2_load_a", 32'(load), 32'h3);
      chk("t2_level_b", 32'(level), 32'd1);
      step();
      chk("t2_ld_en_b", 32'(ld_en), 32'd0);
      chk("t2_level_c", 32'(level), 32'd1);
      step();
      chk("t2_ld_en_c", 32'(ld_en), 32'd1);
      chk("t2_load_c", 32'(load), 32'h6);
      chk("t2_level_d", 32'(level), 32'd0);
      step(); step(); step();
      chk("t2_busy_done", 32'(busy), 32'd0);

      // fill to full on GAP=3 while the FSM sits in WAIT, twice for wrap
      for (int r = 0; r < 2; r++) begin
         push3(4'(r * 8));
         push3(4'(r * 8 + 1));
         push3(4'(r * 8 + 2));
         push3(4'(r * 8 + 3));
         push3(4'(r * 8 + 4));
         chk("t3_level_full", 32'(level3), 32'd4);
         chk("t3_ready_low", 32'(req_ready3), 32'd0);
         push3(4'(r * 8 + 5));
         chk("t3_refused_level", 32'(level3), 32'd3);
         chk("t3_pop_ld_en", 32'(ld_en3), 32'd1);
         chk("t3_pop_load", 32'(load3), 32'(r * 8 + 1));
         repeat (16) step();
         chk("t3_drained_level", 32'(level3), 32'd0);
         chk("t3_drained_busy", 32'(busy3), 32'd0);
         chk("t3_sb_empty", 32'(q3.size()), 32'd0);
      end

      // mismatch detection and sticky behaviour
      bad = 1'b1;
      push(4'b0110);
      step(); step();
      chk("t4_err_before_check", 32'(load_err), 32'd0);
      step();
      chk("t4_err_set", 32'(load_err), 32'd1);
      step();
      chk("t4_err_sticky", 32'(load_err), 32'd1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("t4_err_cleared", 32'(load_err), 32'd0);
      push(4'b0110);
      step(); step();
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("t4_set_wins", 32'(load_err), 32'd1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("t4_err_cleared2", 32'(load_err), 32'd0);
      bad = 1'b0;
      step(); step();

      // reset during ISSUE with two entries queued
      push(4'h1); push(4'h2); push(4'h3); push(4'h4);
      chk("t5_pre_ld_en", 32'(ld_en), 32'd1);
      chk("t5_pre_load", 32'(load), 32'h2);
      chk("t5_pre_level", 32'(level), 32'd2);
      Rst = 1'b1;
      step();
      chk("t5_ld_en", 32'(ld_en), 32'd0);
      chk("t5_level", 32'(level), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_load", 32'(load), 32'd0);
      chk("t5_load_err", 32'(load_err), 32'd0);
      chk("t5_ready", 32'(req_ready), 32'd1);
      Rst = 1'b0;
      q.delete();
      q3.delete();
      repeat (6) step();
      chk("t5_quiet_busy", 32'(busy), 32'd0);
      chk("t5_quiet_ld_en", 32'(ld_en), 32'd0);

      // GAP=3 streaming: exactly three low cycles between pulses
      gaps3.delete();
      push3(4'h7); push3(4'h9); push3(4'hA);
      repeat (14) step();
      chk("t6_pulse_count", 32'(gaps3.size()), 32'd3);
      if (gaps3.size() == 3) begin
         chk("t6_gap_1", 32'(gaps3[1]), 32'd3);
         chk("t6_gap_2", 32'(gaps3[2]), 32'd3);
      end
      chk("t6_busy_done", 32'(busy3), 32'd0);
      chk("t6_err_g3", 32'(load_err3), 32'd0);

      chk("final_sb_g1", 32'(q.size()), 32'd0);
      chk("final_sb_g3", 32'(q3.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
